// File: rtl/noc_loopback_port.sv
// Router-side loopback endpoint: buffers one inbound packet, then replies with the
// header's address halves swapped. A one-flit skid absorbs the sender's credit lag.
module noc_loopback_port #(
  parameter int                    FLIT_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter logic [FLIT_WIDTH-1:0] ADDRESS    = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx,
  input  logic [FLIT_WIDTH-1:0] data_i,
  output logic                  credit_o,
  output logic                  tx,
  output logic [FLIT_WIDTH-1:0] data_o,
  input  logic                  credit_i,
  output logic [15:0]           pkt_count_out,
  output logic [15:0]           drop_count_out,
  output logic [2:0]            rstate_out,
  output logic [2:0]            tstate_out,
  output logic [FLIT_WIDTH-1:0] addr_out
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = AW + 1;
  localparam int HALF = FLIT_WIDTH / 2;
  localparam logic [FLIT_WIDTH-1:0] DEPTH_W = FLIT_WIDTH'(DEPTH);

  typedef enum logic [2:0] {
    RX_HEADER  = 3'd0,
    RX_SIZE    = 3'd1,
    RX_PAYLOAD = 3'd2,
    RX_DRAIN   = 3'd3,
    RX_HOLD    = 3'd4
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_HEADER  = 3'd1,
    TX_SIZE    = 3'd2,
    TX_PAYLOAD = 3'd3,
    TX_DONE    = 3'd4
  } tx_state_t;

  rx_state_t rstate_reg, rstate_next;
  tx_state_t tstate_reg, tstate_next;

  logic                  credit_reg, credit_next;
  logic                  skid_full_reg;
  logic [FLIT_WIDTH-1:0] skid_data_reg;
  logic [FLIT_WIDTH-1:0] hdr_reg;
  logic [FLIT_WIDTH-1:0] size_reg;
  logic [FLIT_WIDTH-1:0] drain_cnt_reg;
  logic [PW-1:0]         wptr_reg;
  logic [PW-1:0]         rptr_reg;
  logic                  pkt_ready_reg;
  logic                  tx_reg;
  logic                  out_sel_reg;
  logic [FLIT_WIDTH-1:0] out_reg;
  logic [FLIT_WIDTH-1:0] rd_data_reg;
  logic [15:0]           pkt_count_reg;
  logic [15:0]           drop_count_reg;
  logic [FLIT_WIDTH-1:0] mem [DEPTH];

  logic                  accepting;
  logic                  in_valid;
  logic [FLIT_WIDTH-1:0] in_data;
  logic [PW-1:0]         wptr_inc;
  logic [PW-1:0]         rptr_inc;
  logic [FLIT_WIDTH-1:0] drain_cnt_inc;
  logic                  payload_last;
  logic                  drain_last;
  logic                  tx_last;
  logic                  xfer;
  logic                  tx_done;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;

  // A held skid flit always takes precedence so packet order is preserved.
  assign accepting     = (rstate_reg != RX_HOLD);
  assign in_valid      = accepting && (skid_full_reg || (rx && credit_reg));
  assign in_data       = skid_full_reg ? skid_data_reg : data_i;
  assign wptr_inc      = wptr_reg + 1'b1;
  assign rptr_inc      = rptr_reg + 1'b1;
  assign drain_cnt_inc = drain_cnt_reg + 1'b1;
  assign payload_last  = ({{(FLIT_WIDTH-PW){1'b0}}, wptr_inc} == size_reg);
  assign drain_last    = (drain_cnt_inc == size_reg);
  assign tx_last       = ({{(FLIT_WIDTH-PW){1'b0}}, rptr_inc} == size_reg);
  assign xfer          = tx_reg && credit_i;
  assign tx_done       = (tstate_reg == TX_DONE);

  always_comb begin
    rstate_next = rstate_reg;
    case (rstate_reg)
      RX_HEADER:  if (in_valid) rstate_next = RX_SIZE;
      RX_SIZE: begin
        if (in_valid) begin
          if (in_data > DEPTH_W)       rstate_next = RX_DRAIN;
          else if (in_data == '0)      rstate_next = RX_HOLD;
          else                         rstate_next = RX_PAYLOAD;
        end
      end
      RX_PAYLOAD: if (in_valid && payload_last) rstate_next = RX_HOLD;
      RX_DRAIN:   if (in_valid && drain_last)   rstate_next = RX_HEADER;
      RX_HOLD:    if (tx_done)                  rstate_next = RX_HEADER;
      default:    rstate_next = RX_HEADER;
    endcase
  end

  // Credit drops for one cycle after a drained packet so a following header lands in the skid.
  assign credit_next = (rstate_next != RX_HOLD) &&
                       !((rstate_reg == RX_DRAIN) && in_valid && drain_last);

  always_ff @(posedge clock) begin
    if (reset) begin
      rstate_reg     <= RX_HEADER;
      credit_reg     <= 1'b0;
      skid_full_reg  <= 1'b0;
      skid_data_reg  <= '0;
      hdr_reg        <= '0;
      size_reg       <= '0;
      drain_cnt_reg  <= '0;
      wptr_reg       <= '0;
      pkt_ready_reg  <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      rstate_reg    <= rstate_next;
      credit_reg    <= credit_next;
      pkt_ready_reg <= (rstate_next == RX_HOLD) && (rstate_reg != RX_HOLD);
      if (skid_full_reg) begin
        if (accepting) begin
          if (rx) skid_data_reg <= data_i;
          else    skid_full_reg <= 1'b0;
        end
      end else if (rx && !(accepting && credit_reg)) begin
        skid_full_reg <= 1'b1;
        skid_data_reg <= data_i;
      end
      if (in_valid) begin
        case (rstate_reg)
          RX_HEADER: hdr_reg <= in_data;
          RX_SIZE: begin
            size_reg      <= in_data;
            wptr_reg      <= '0;
            drain_cnt_reg <= '0;
          end
          RX_PAYLOAD: wptr_reg <= wptr_inc;
          RX_DRAIN: begin
            drain_cnt_reg <= drain_cnt_inc;
            if (drain_last) drop_count_reg <= drop_count_reg + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_en   = xfer && (((tstate_reg == TX_SIZE) && (size_reg != '0)) ||
                            ((tstate_reg == TX_PAYLOAD) && !tx_last));
  assign rd_addr = (tstate_reg == TX_SIZE) ? '0 : rptr_inc[AW-1:0];

  always_ff @(posedge clock) begin
    if (in_valid && (rstate_reg == RX_PAYLOAD)) mem[wptr_reg[AW-1:0]] <= in_data;
    if (rd_en) rd_data_reg <= mem[rd_addr];
  end

  always_comb begin
    tstate_next = tstate_reg;
    case (tstate_reg)
      TX_IDLE:    if (pkt_ready_reg) tstate_next = TX_HEADER;
      TX_HEADER:  if (xfer) tstate_next = TX_SIZE;
      TX_SIZE:    if (xfer) tstate_next = (size_reg == '0) ? TX_DONE : TX_PAYLOAD;
      TX_PAYLOAD: if (xfer && tx_last) tstate_next = TX_DONE;
      TX_DONE:    tstate_next = TX_IDLE;
      default:    tstate_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tstate_reg    <= TX_IDLE;
      tx_reg        <= 1'b0;
      out_sel_reg   <= 1'b0;
      out_reg       <= '0;
      rptr_reg      <= '0;
      pkt_count_reg <= '0;
    end else begin
      tstate_reg <= tstate_next;
      case (tstate_reg)
        TX_IDLE: begin
          if (pkt_ready_reg) begin
            out_reg     <= {hdr_reg[HALF-1:0], hdr_reg[FLIT_WIDTH-1:HALF]};
            out_sel_reg <= 1'b0;
            tx_reg      <= 1'b1;
          end
        end
        TX_HEADER: if (xfer) out_reg <= size_reg;
        TX_SIZE: begin
          if (xfer) begin
            rptr_reg <= '0;
            if (size_reg == '0) tx_reg      <= 1'b0;
            else                out_sel_reg <= 1'b1;
          end
        end
        TX_PAYLOAD: begin
          if (xfer) begin
            if (tx_last) tx_reg   <= 1'b0;
            else         rptr_reg <= rptr_inc;
          end
        end
        TX_DONE: pkt_count_reg <= pkt_count_reg + 16'd1;
        default: ;
      endcase
    end
  end

  assign credit_o       = credit_reg;
  assign tx             = tx_reg;
  assign data_o         = out_sel_reg ? rd_data_reg : out_reg;
  assign pkt_count_out  = pkt_count_reg;
  assign drop_count_out = drop_count_reg;
  assign rstate_out     = rstate_reg;
  assign tstate_out     = tstate_reg;
  assign addr_out       = ADDRESS;

endmodule

// File: tb/tb_noc_loopback_port.sv
// Scoreboard bench: a credit-lagged sender feeds packets, a monitor checks every reply flit.
module tb_noc_loopback_port;
  localparam int          FW    = 32;
  localparam int          DEPTH = 64;
  localparam logic [31:0] ADDR  = 32'h0000_0A05;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx = 1'b0;
  logic [FW-1:0] data_i = '0;
  logic          credit_o;
  logic          tx;
  logic [FW-1:0] data_o;
  logic          credit_i = 1'b0;
  logic [15:0]   pkt_count_out;
  logic [15:0]   drop_count_out;
  logic [2:0]    rstate_out;
  logic [2:0]    tstate_out;
  logic [FW-1:0] addr_out;

  noc_loopback_port #(.FLIT_WIDTH(FW), .DEPTH(DEPTH), .ADDRESS(ADDR)) dut (
    .clock(clock), .reset(reset), .rx(rx), .data_i(data_i), .credit_o(credit_o),
    .tx(tx), .data_o(data_o), .credit_i(credit_i),
    .pkt_count_out(pkt_count_out), .drop_count_out(drop_count_out),
    .rstate_out(rstate_out), .tstate_out(tstate_out), .addr_out(addr_out)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] drv_q[$];
  logic [31:0] exp_q[$];
  int          exp_pkts = 0;
  int          exp_drops = 0;
  int          credit_mode = 0;
  int          cyc = 0;
  int          flit_no = 0;
  logic        credit_seen = 1'b0;
  logic [3:0]  pat = 4'b1001;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic send_packet(input logic [31:0] hdr, input logic [31:0] n, input logic [31:0] seed);
    logic [31:0] w;
    logic        keep;
    keep = (n <= 32'(DEPTH));
    drv_q.push_back(hdr);
    drv_q.push_back(n);
    if (keep) begin
      exp_q.push_back({hdr[15:0], hdr[31:16]});
      exp_q.push_back(n);
      exp_pkts++;
    end else begin
      exp_drops++;
    end
    for (int i = 0; i < int'(n); i++) begin
      w = seed + 32'(i) * 32'h11;
      drv_q.push_back(w);
      if (keep) exp_q.push_back(w);
    end
    $display("send hdr=%h n=%0d", hdr, n);
  endtask

  task automatic wait_idle(input int budget);
    int   n;
    logic idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < budget) begin
      @(negedge clock);
      n++;
      idle = (drv_q.size() == 0) && (exp_q.size() == 0) && !tx &&
             (rstate_out == 3'd0) && (tstate_out == 3'd0);
    end
    check("idle_reached", {31'b0, idle}, 32'd1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_pkts"}, {16'b0, pkt_count_out}, 32'(exp_pkts));
    check({tag, "_drops"}, {16'b0, drop_count_out}, 32'(exp_drops));
  endtask

  // Sender: may drive a flit only if credit was high in the previous cycle.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (!reset && credit_seen && drv_q.size() > 0) begin
        rx     = 1'b1;
        data_i = drv_q.pop_front();
      end else begin
        rx     = 1'b0;
        data_i = '0;
      end
      case (credit_mode)
        0:       credit_i = 1'b1;
        1:       credit_i = pat[cyc % 4];
        default: credit_i = 1'($urandom_range(0, 1));
      endcase
      cyc++;
    end
  end

  // Monitor: compares transfers against the scoreboard and checks stall stability.
  initial begin
    logic        hold_valid;
    logic [31:0] hold_data;
    logic [31:0] want;
    hold_valid = 1'b0;
    hold_data  = '0;
    forever begin
      @(negedge clock);
      credit_seen = credit_o;
      if (reset) begin
        hold_valid = 1'b0;
      end else begin
        if (hold_valid) begin
          check("stall_tx", {31'b0, tx}, 32'd1);
          check("stall_data", data_o, hold_data);
          hold_valid = 1'b0;
        end
        if (tx && credit_i) begin
          if (exp_q.size() == 0) begin
            check("extra_flit", {31'b0, tx}, 32'd0);
          end else begin
            want = exp_q.pop_front();
            $display("flit %0d data=%h expect=%h", flit_no, data_o, want);
            check("reply_flit", data_o, want);
          end
          flit_no++;
        end else if (tx) begin
          hold_valid = 1'b1;
          hold_data  = data_o;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_credit", {31'b0, credit_o}, 32'd0);
    check("rst_tx", {31'b0, tx}, 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_rstate", {29'b0, rstate_out}, 32'd0);
    check("rst_tstate", {29'b0, tstate_out}, 32'd0);
    check("addr_out", addr_out, ADDR);
    check_counts("rst");
    reset = 1'b0;

    // Basic loopback with continuous credit.
    credit_mode = 0;
    send_packet(32'h0002_0001, 32'd3, 32'h0000_00A1);
    wait_idle(300);
    check_counts("t1");

    // Same packet with stalling receiver.
    credit_mode = 1;
    send_packet(32'h0002_0001, 32'd3, 32'h0000_00A1);
    wait_idle(300);
    check_counts("t2");

    // Empty payload.
    credit_mode = 0;
    send_packet(32'h1234_5678, 32'd0, 32'd0);
    wait_idle(300);
    check_counts("t3");

    // Oversize packet is drained, following packet still loops back.
    send_packet(32'hCAFE_0001, 32'(DEPTH + 1), 32'h0000_0100);
    send_packet(32'h0030_0004, 32'd2, 32'h0000_0055);
    wait_idle(800);
    check_counts("t4");

    // Back-to-back packets: second header lands in the skid.
    send_packet(32'h0A0B_0C0D, 32'd4, 32'h0000_1000);
    send_packet(32'h1111_2222, 32'd3, 32'h0000_2000);
    wait_idle(400);
    check_counts("t5");

    // Full-depth packet plus short random ones under random credit.
    credit_mode = 2;
    send_packet(32'h7777_8888, 32'(DEPTH), 32'h0000_3000);
    for (int k = 0; k < 4; k++) begin
      send_packet($urandom, 32'($urandom_range(1, 8)), $urandom);
    end
    wait_idle(3000);
    check_counts("rand");

    // Reset in the middle of the reply payload.
    credit_mode = 0;
    send_packet(32'h0F0F_1234, 32'd8, 32'h0000_4000);
    n = 0;
    while (tstate_out != 3'd3 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("reach_tx_payload", {29'b0, tstate_out}, 32'd3);
    reset = 1'b1;
    drv_q.delete();
    exp_q.delete();
    exp_pkts  = 0;
    exp_drops = 0;
    @(negedge clock);
    check("mid_rst_tx", {31'b0, tx}, 32'd0);
    check("mid_rst_credit", {31'b0, credit_o}, 32'd0);
    check_counts("mid_rst");
    reset = 1'b0;
    send_packet(32'h0005_0006, 32'd2, 32'h0000_0077);
    wait_idle(300);
    check_counts("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_loopback_port.md
Name: noc_loopback_port

Overview:
- Router-side endpoint for the DDMA router port.
- Accepts packets the DDMA transmits (rx/data_i/credit_o) into a store-and-forward buffer, then returns each packet to the DDMA receive path (tx/data_o/credit_i) with the header's address halves swapped.
- Used as a stand-in for the NoC in pkt-sim DDMA benches, and as a loopback tile in single-node builds.

Parameters:
- FLIT_WIDTH, 32, flit width in bits; must be 32 so the header halves split cleanly.
- DEPTH, 64, payload buffer entries in flits; must be a power of two, at least 4.
- ADDRESS, 0, this port's node address; reported on addr_out only.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx  in  1  flit valid from the DDMA; one flit is transferred on each cycle rx==1
- data_i  in  FLIT_WIDTH  flit from the DDMA
- credit_o  out  1  DDMA may send a flit next cycle
- tx  out  1  outbound flit valid
- data_o  out  FLIT_WIDTH  outbound flit
- credit_i  in  1  DDMA accepts data_o this cycle (transfer when tx==1 and credit_i==1)
- pkt_count_out  out  16  packets looped back; wraps at 0xFFFF to 0
- drop_count_out  out  16  oversize packets dropped; wraps at 0xFFFF to 0
- rstate_out  out  3  receive FSM state encoding
- tstate_out  out  3  transmit FSM state encoding
- addr_out  out  FLIT_WIDTH  constant ADDRESS

Behaviour:
- Reset (synchronous, active-high, clock edge with reset==1):
  - credit_o=0, tx=0, data_o=0, both counters 0, skid register empty.
  - RX FSM goes to RX_HEADER, TX FSM goes to TX_IDLE.
  - Reset mid-packet discards all buffered flits.
- Packet format: flit0 = header, flit1 = size N (payload flit count), then N payload flits.
- credit_o is registered:
  - 1 while RX is in RX_HEADER, RX_SIZE or RX_PAYLOAD.
  - 0 in RX_DRAIN-end and RX_HOLD, and the cycle after reset.
- Skid register (1 flit):
  - A flit with rx==1 while credit_o==0 is captured into the skid register; it covers the DDMA's one-cycle credit sampling latency.
  - On re-entry to RX_HEADER with the skid full, the skid flit is consumed as the header in that cycle.
  - A second flit arriving while the skid is full is a protocol violation; it is ignored.
- RX FSM:
  - RX_HEADER: on rx, store the header and go to RX_SIZE.
  - RX_SIZE: on rx, store N and clear the write pointer.
    - If N > DEPTH, go to RX_DRAIN.
    - Else if N == 0, go to RX_HOLD.
    - Else go to RX_PAYLOAD.
  - RX_PAYLOAD: on rx, write buffer[wptr] and increment wptr; go to RX_HOLD on the Nth flit.
  - RX_DRAIN: accept and discard N flits; drop_count_out +1 on the last one, then go to RX_HEADER. No reply is generated.
  - RX_HOLD: assert a one-cycle pkt_ready pulse to TX, stay until TX reports done, then go to RX_HEADER.
- TX FSM:
  - TX_IDLE: on pkt_ready, load data_o = {hdr[15:0], hdr[31:16]}, set tx=1, go to TX_HEADER.
  - TX_HEADER: on transfer, data_o=N, go to TX_SIZE.
  - TX_SIZE: on transfer, go to TX_PAYLOAD with data_o=buffer[0], or to TX_DONE if N==0.
  - TX_PAYLOAD: on transfer, present buffer[rptr+1]; go to TX_DONE after the Nth transfer.
  - TX_DONE: tx=0, pkt_count_out +1, signal done to RX for one cycle, go to TX_IDLE.
- Handshake rules:
  - data_o and tx hold stable until a transfer occurs.
  - Back-to-back transfers are allowed (credit_i held at 1), one flit per cycle.
  - With credit_i==0 indefinitely, TX stalls and no flit is ever dropped.
- Latency: the first reply flit is on data_o 2 cycles after the last inbound flit is accepted (N≥1).
- Simultaneous events: rx activity during TX is captured only by the skid. No new packet is accepted until TX_DONE (single packet buffer).
- Width rules: N is taken as the full FLIT_WIDTH value and the N > DEPTH compare is unsigned. Pointers are log2(DEPTH)+1 bits.

Test Plan:
1. Send header 0x00020001, size 3, payload A1,B2,C3 with credit_i=1 -> tx flits 0x00010002, 3, A1, B2, C3; pkt_count_out=1.
2. Same packet with credit_i toggling 1-0-0-1 -> identical flit sequence, data_o stable during stalls, no duplicate or lost flits.
3. Header, size 0 -> reply is swapped header then 0, then tx=0; pkt_count_out increments.
4. Size DEPTH+1 with 65 payload flits -> no tx; drop_count_out=1; the next valid packet loops back correctly.
5. A new header arrives one cycle after credit_o falls -> held in the skid; after the first reply completes, the second packet is looped back with that header.
6. Reset asserted during TX_PAYLOAD -> next cycle tx=0, credit_o=0, counters 0; a fresh packet then loops back normally.
